// File: rtl/hood_pkg.sv
// rtl/hood_pkg.sv - mode encodings, fan levels and default durations for the hood core
package hood_pkg;

  typedef enum logic [2:0] {
    MODE_OFF      = 3'd0,
    MODE_STANDBY  = 3'd1,
    MODE_MENU     = 3'd2,
    MODE_LVL1     = 3'd3,
    MODE_LVL2     = 3'd4,
    MODE_LVL3     = 3'd5,
    MODE_L3_EXIT  = 3'd6,
    MODE_CLEAN    = 3'd7
  } mode_e;

  localparam logic [1:0] FAN_STOP = 2'd0;
  localparam logic [1:0] FAN_L1   = 2'd1;
  localparam logic [1:0] FAN_L2   = 2'd2;
  localparam logic [1:0] FAN_L3   = 2'd3;

  localparam int unsigned DEF_TICK_CYCLES     = 100_000_000;
  localparam int unsigned DEF_L3_SECONDS      = 60;
  localparam int unsigned DEF_L3_EXIT_SECONDS = 60;
  localparam int unsigned DEF_CLEAN_SECONDS   = 180;

  // Self-clean runs with the fan stopped; L3_EXIT keeps the burst speed as run-on.
  function automatic logic [1:0] fan_for_mode(input mode_e m);
    logic [1:0] f;
    f = FAN_STOP;
    case (m)
      MODE_LVL1:    f = FAN_L1;
      MODE_LVL2:    f = FAN_L2;
      MODE_LVL3:    f = FAN_L3;
      MODE_L3_EXIT: f = FAN_L3;
      default:      f = FAN_STOP;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// rtl/sec_tick_gen.sv - one-second prescaler with synchronous clear and single-cycle tick
module sec_tick_gen #(
  parameter int unsigned TICK_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // tick must not depend on clr: clr is derived from a mode change the tick itself can cause.
  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hood_mode_controller.sv
// rtl/hood_mode_controller.sv - range-hood mode FSM with timed level-3, run-on and self-clean
module hood_mode_controller #(
  parameter int unsigned TICK_CYCLES     = hood_pkg::DEF_TICK_CYCLES,
  parameter int unsigned L3_SECONDS      = hood_pkg::DEF_L3_SECONDS,
  parameter int unsigned L3_EXIT_SECONDS = hood_pkg::DEF_L3_EXIT_SECONDS,
  parameter int unsigned CLEAN_SECONDS   = hood_pkg::DEF_CLEAN_SECONDS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_on,
  input  logic       menu_p,
  input  logic       lvl1_p,
  input  logic       lvl2_p,
  input  logic       lvl3_p,
  input  logic       clean_p,
  output logic [2:0] mode,
  output logic [1:0] fan_level,
  output logic [7:0] countdown_s,
  output logic       lvl3_used,
  output logic       clean_done
);

  import hood_pkg::*;

  localparam logic [7:0] L3_LOAD      = 8'(L3_SECONDS);
  localparam logic [7:0] L3_EXIT_LOAD = 8'(L3_EXIT_SECONDS);
  localparam logic [7:0] CLEAN_LOAD   = 8'(CLEAN_SECONDS);

  mode_e      mode_q, mode_d;
  logic [7:0] cd_q, cd_d;
  logic       used_q, used_d;
  logic       cdone_q, cdone_d;
  logic       tick;
  logic       last_sec;
  logic       clr;

  assign last_sec = (cd_q == 8'd1);
  assign clr      = (mode_d != mode_q);

  sec_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    mode_d  = mode_q;
    cd_d    = cd_q;
    used_d  = used_q;
    cdone_d = 1'b0;
    if (!power_on) begin
      mode_d = MODE_OFF;
      cd_d   = 8'd0;
      used_d = 1'b0;
    end else begin
      case (mode_q)
        MODE_OFF: mode_d = MODE_STANDBY;
        MODE_STANDBY: begin
          if (menu_p) mode_d = MODE_MENU;
        end
        // A winning key that is not legal here is still consumed; lower keys are dropped.
        MODE_MENU: begin
          if (menu_p) begin
            mode_d = MODE_STANDBY;
          end else if (clean_p) begin
            mode_d = MODE_CLEAN;
            cd_d   = CLEAN_LOAD;
          end else if (lvl3_p) begin
            if (!used_q) begin
              mode_d = MODE_LVL3;
              cd_d   = L3_LOAD;
              used_d = 1'b1;
            end
          end else if (lvl2_p) begin
            mode_d = MODE_LVL2;
          end else if (lvl1_p) begin
            mode_d = MODE_LVL1;
          end
        end
        MODE_LVL1, MODE_LVL2: begin
          if (menu_p) begin
            mode_d = MODE_STANDBY;
          end else if (!clean_p && !lvl3_p) begin
            if (lvl2_p)      mode_d = MODE_LVL2;
            else if (lvl1_p) mode_d = MODE_LVL1;
          end
        end
        MODE_LVL3: begin
          if (menu_p) begin
            mode_d = MODE_L3_EXIT;
            cd_d   = L3_EXIT_LOAD;
          end else if (tick) begin
            if (last_sec) begin
              mode_d = MODE_LVL2;
              cd_d   = 8'd0;
            end else begin
              cd_d = cd_q - 8'd1;
            end
          end
        end
        MODE_L3_EXIT, MODE_CLEAN: begin
          if (tick) begin
            if (last_sec) begin
              mode_d  = MODE_STANDBY;
              cd_d    = 8'd0;
              cdone_d = (mode_q == MODE_CLEAN);
            end else begin
              cd_d = cd_q - 8'd1;
            end
          end
        end
        default: mode_d = MODE_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MODE_OFF;
      cd_q    <= 8'd0;
      used_q  <= 1'b0;
      cdone_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      cd_q    <= cd_d;
      used_q  <= used_d;
      cdone_q <= cdone_d;
    end
  end

  assign mode        = mode_q;
  assign fan_level   = fan_for_mode(mode_q);
  assign countdown_s = cd_q;
  assign lvl3_used   = used_q;
  assign clean_done  = cdone_q;

endmodule

// File: tb/tb_hood_mode_controller.sv
// tb/tb_hood_mode_controller.sv - scoreboard bench for hood_mode_controller with TICK_CYCLES=10
module tb_hood_mode_controller;

  localparam logic [2:0] M_OFF = 3'd0, M_STBY = 3'd1, M_MENU = 3'd2, M_L1 = 3'd3;
  localparam logic [2:0] M_L2 = 3'd4, M_L3 = 3'd5, M_L3X = 3'd6, M_CLEAN = 3'd7;
  localparam logic [4:0] K_NONE = 5'b00000, K_MENU = 5'b10000, K_CLEAN = 5'b01000;
  localparam logic [4:0] K_L3 = 5'b00100, K_L2 = 5'b00010, K_L1 = 5'b00001;

  typedef struct {
    string      tag;
    logic [2:0] mode;
    logic [1:0] fan;
    logic [7:0] cd;
    logic       used;
    logic       cdone;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       power_on;
  logic       menu_p, lvl1_p, lvl2_p, lvl3_p, clean_p;
  logic [2:0] mode;
  logic [1:0] fan_level;
  logic [7:0] countdown_s;
  logic       lvl3_used;
  logic       clean_done;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  hood_mode_controller #(
    .TICK_CYCLES     (10),
    .L3_SECONDS      (60),
    .L3_EXIT_SECONDS (60),
    .CLEAN_SECONDS   (180)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .power_on    (power_on),
    .menu_p      (menu_p),
    .lvl1_p      (lvl1_p),
    .lvl2_p      (lvl2_p),
    .lvl3_p      (lvl3_p),
    .clean_p     (clean_p),
    .mode        (mode),
    .fan_level   (fan_level),
    .countdown_s (countdown_s),
    .lvl3_used   (lvl3_used),
    .clean_done  (clean_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [2:0] m, input logic [1:0] f,
                              input logic [7:0] cd, input logic used, input logic cdone);
    exp_t e;
    e.tag = tag; e.mode = m; e.fan = f; e.cd = cd; e.used = used; e.cdone = cdone;
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, ".mode"}, 32'(mode), 32'(e.mode));
      check({e.tag, ".fan"}, 32'(fan_level), 32'(e.fan));
      check({e.tag, ".countdown"}, 32'(countdown_s), 32'(e.cd));
      check({e.tag, ".lvl3_used"}, 32'(lvl3_used), 32'(e.used));
      check({e.tag, ".clean_done"}, 32'(clean_done), 32'(e.cdone));
    end
  endtask

  // Called at a negedge: drive keys for one cycle, check the registered result one cycle later.
  task automatic apply(input logic [4:0] keys, input exp_t e);
    {menu_p, clean_p, lvl3_p, lvl2_p, lvl1_p} = keys;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    {menu_p, clean_p, lvl3_p, lvl2_p, lvl1_p} = K_NONE;
    @(negedge clk);
    compare_out();
  endtask

  task automatic wait_expect(input int n, input exp_t e);
    sb_q.push_back(e);
    repeat (n) @(negedge clk);
    compare_out();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    power_on = 1'b0;
    {menu_p, clean_p, lvl3_p, lvl2_p, lvl1_p} = K_NONE;
    repeat (2) @(negedge clk);
    sb_q.push_back(mk("reset", M_OFF, 0, 0, 0, 0));
    compare_out();
    rst = 1'b1;
    wait_expect(2, mk("unpowered", M_OFF, 0, 0, 0, 0));

    power_on = 1'b1;
    apply(K_NONE, mk("power_up", M_STBY, 0, 0, 0, 0));
    apply(K_L1,   mk("stby_ignore_l1", M_STBY, 0, 0, 0, 0));
    apply(K_MENU, mk("menu", M_MENU, 0, 0, 0, 0));
    apply(K_L2,   mk("lvl2", M_L2, 2, 0, 0, 0));
    apply(K_L1,   mk("lvl1", M_L1, 1, 0, 0, 0));
    apply(K_L3,   mk("lvl1_ignore_l3", M_L1, 1, 0, 0, 0));
    apply(K_MENU, mk("lvl1_menu", M_STBY, 0, 0, 0, 0));

    apply(K_MENU, mk("menu2", M_MENU, 0, 0, 0, 0));
    apply(K_L3,   mk("lvl3_entry", M_L3, 3, 60, 1, 0));
    wait_expect(599, mk("lvl3_last_sec", M_L3, 3, 1, 1, 0));
    wait_expect(1,   mk("lvl3_timeout", M_L2, 2, 0, 1, 0));
    apply(K_MENU, mk("l2_menu", M_STBY, 0, 0, 1, 0));
    apply(K_MENU, mk("menu3", M_MENU, 0, 0, 1, 0));
    apply(K_L3 | K_L2, mk("lvl3_used_ignored", M_MENU, 0, 0, 1, 0));

    power_on = 1'b0;
    apply(K_NONE, mk("power_off", M_OFF, 0, 0, 0, 0));
    power_on = 1'b1;
    apply(K_NONE, mk("power_up2", M_STBY, 0, 0, 0, 0));
    apply(K_MENU, mk("menu4", M_MENU, 0, 0, 0, 0));
    apply(K_L3,   mk("lvl3_entry2", M_L3, 3, 60, 1, 0));
    wait_expect(180, mk("lvl3_at_42", M_L3, 3, 42, 1, 0));
    apply(K_MENU, mk("l3_exit_entry", M_L3X, 3, 60, 1, 0));
    apply(K_L1,   mk("l3_exit_ignore_l1", M_L3X, 3, 60, 1, 0));
    wait_expect(598, mk("l3_exit_last_sec", M_L3X, 3, 1, 1, 0));
    wait_expect(1,   mk("l3_exit_timeout", M_STBY, 0, 0, 1, 0));

    apply(K_MENU, mk("menu5", M_MENU, 0, 0, 1, 0));
    apply(K_MENU | K_L3, mk("menu_beats_l3", M_STBY, 0, 0, 1, 0));
    apply(K_MENU, mk("menu6", M_MENU, 0, 0, 1, 0));
    apply(K_CLEAN | K_L1, mk("clean_beats_l1", M_CLEAN, 0, 180, 1, 0));
    wait_expect(1799, mk("clean_last_sec", M_CLEAN, 0, 1, 1, 0));
    wait_expect(1,    mk("clean_done_pulse", M_STBY, 0, 0, 1, 1));
    wait_expect(1,    mk("clean_done_drop", M_STBY, 0, 0, 1, 0));

    apply(K_MENU,  mk("menu7", M_MENU, 0, 0, 1, 0));
    apply(K_CLEAN, mk("clean_entry2", M_CLEAN, 0, 180, 1, 0));
    wait_expect(900, mk("clean_at_90", M_CLEAN, 0, 90, 1, 0));
    power_on = 1'b0;
    apply(K_NONE, mk("clean_power_off", M_OFF, 0, 0, 0, 0));

    power_on = 1'b1;
    apply(K_NONE, mk("power_up3", M_STBY, 0, 0, 0, 0));
    apply(K_MENU, mk("menu8", M_MENU, 0, 0, 0, 0));
    apply(K_L3,   mk("lvl3_entry3", M_L3, 3, 60, 1, 0));
    wait_expect(50, mk("lvl3_at_55", M_L3, 3, 55, 1, 0));
    #2;
    rst = 1'b0;
    #1;
    sb_q.push_back(mk("async_reset", M_OFF, 0, 0, 0, 0));
    compare_out();
    wait_expect(1, mk("reset_held", M_OFF, 0, 0, 0, 0));
    rst = 1'b1;
    apply(K_NONE, mk("after_reset", M_STBY, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
